// File: rtl/ahb_sub_mem.sv
// AHB subordinate word memory with configurable wait states and two-cycle ERROR response.
// Storage is register-based so the whole array clears on reset.
module ahb_sub_mem #(
  parameter int          MEM_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic            write_reg, write_next;
  logic [31:0]     mem_reg [MEM_DEPTH];

  logic            accept;
  logic            addr_err;
  logic            mem_we;
  logic            unused_hburst;

  // Each beat is decoded on its own, so the burst type carries no information here.
  assign unused_hburst = ^HBURST;

  // BASE_ADDR is aligned to the region size, so range is a compare of the upper bits.
  assign addr_err = (HADDR[31:AW+2] != BASE_ADDR[31:AW+2]) ||
                    (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00);
  assign accept   = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign mem_we   = (state_reg == S_DATA) && write_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    write_next = write_reg;
    HREADYOUT  = 1'b1;
    HRESP      = 2'b00;
    HRDATA     = 32'h0;
    case (state_reg)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_reg == 3'd0) state_next = S_DATA;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      S_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 2'b01;
        state_next = S_ERR2;
      end
      S_ERR2: begin
        HRESP      = 2'b01;
        state_next = S_IDLE;
      end
      S_DATA: begin
        if (!write_reg) HRDATA = mem_reg[idx_reg];
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Accepting is only possible while ready, so this overrides the IDLE fall-back.
    if (accept) begin
      idx_next   = HADDR[AW+1:2];
      write_next = HWRITE;
      cnt_next   = WS_LOAD;
      if (addr_err)              state_next = S_ERR1;
      else if (WAIT_STATES == 0) state_next = S_DATA;
      else                       state_next = S_WAIT;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
      idx_reg   <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      write_reg <= write_next;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_reg[i] <= 32'h0;
    end else if (mem_we) begin
      mem_reg[idx_reg] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_sub_mem.sv
// Directed bench: three instances (WAIT_STATES 1, 0, 3) on one bus, selected by cur.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_ahb_sub_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [1:0]  cur;

  logic        hsel_v  [3];
  logic        ro_v    [3];
  logic [1:0]  resp_v  [3];
  logic [31:0] rdata_v [3];
  logic        hready;
  logic        cur_ro;
  logic [1:0]  cur_resp;
  logic [31:0] cur_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WS = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;
    assign hsel_v[gi] = hsel && (cur == 2'(gi));
    ahb_sub_mem #(.MEM_DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) u_dut (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_v[gi]), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(ro_v[gi]),
      .HRESP(resp_v[gi]), .HRDATA(rdata_v[gi])
    );
  end

  assign hready    = ro_v[cur];
  assign cur_ro    = ro_v[cur];
  assign cur_resp  = resp_v[cur];
  assign cur_rdata = rdata_v[cur];

  task automatic addr_phase(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                            input logic [2:0] sz);
    hsel = 1'b1; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic bus_idle();
    hsel = 1'b1; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output bit ok);
    d = 32'h0; r = 2'b00; ok = 1'b0;
    addr_phase(2'b10, 1'b0, a, 3'b010);
    @(negedge clk);
    bus_idle();
    for (int k = 0; k < 20; k++) begin
      if (cur_ro) begin d = cur_rdata; r = cur_resp; ok = 1'b1; break; end
      @(negedge clk);
    end
    $display("txn inst=%0d RD addr=%h data=%h resp=%0d done=%0d", cur, a, d, r, ok);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                          output logic [1:0] r, output int k_out, output bit ok);
    r = 2'b00; k_out = -1; ok = 1'b0;
    addr_phase(2'b10, 1'b1, a, sz);
    @(negedge clk);
    bus_idle();
    hwdata = d;
    for (int k = 0; k < 20; k++) begin
      if (cur_ro) begin r = cur_resp; k_out = k; ok = 1'b1; break; end
      @(negedge clk);
    end
    // Hold HWDATA across the committing edge.
    @(negedge clk);
    $display("txn inst=%0d WR addr=%h data=%h size=%0d resp=%0d waits=%0d", cur, a, d, sz, r, k_out);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cur = 2'd0;
    hburst = 3'b000;
    hwdata = 32'h0;
    haddr = 32'h0;
    bus_idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ({ro_v[i], resp_v[i], rdata_v[i]} !== {1'b1, 2'b00, 32'h0}) begin
          n_bad++;
          $display("FAIL reset_idle inst=%0d cyc=%0d: got %h want %h", i, c,
                   {ro_v[i], resp_v[i], rdata_v[i]}, {1'b1, 2'b00, 32'h0});
        end
      end
      if (c == 1) rst_n = 1'b1;
    end
  endtask

  task automatic test_write_read_ws1();
    cur = 2'd0;
    addr_phase(2'b10, 1'b1, 32'h08, 3'b010);
    @(negedge clk);
    n_cmp++;
    if ({cur_ro, cur_resp} !== 3'b0_00) begin
      n_bad++; $display("FAIL ws1_wr_wait: got %b want 000", {cur_ro, cur_resp});
    end
    addr_phase(2'b10, 1'b0, 32'h08, 3'b010);
    hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({cur_ro, cur_resp} !== 3'b1_00) begin
      n_bad++; $display("FAIL ws1_wr_done: got %b want 100", {cur_ro, cur_resp});
    end
    @(negedge clk);
    bus_idle();
    n_cmp++;
    if ({cur_ro, cur_resp} !== 3'b0_00) begin
      n_bad++; $display("FAIL ws1_rd_wait: got %b want 000", {cur_ro, cur_resp});
    end
    @(negedge clk);
    n_cmp++;
    if ({cur_ro, cur_resp, cur_rdata} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL ws1_rd_data: got %h want %h", {cur_ro, cur_resp, cur_rdata},
                        {1'b1, 2'b00, 32'hDEAD_BEEF});
    end
    @(negedge clk);
    n_cmp++;
    if ({cur_ro, cur_rdata} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL ws1_idle_after: got %h want %h", {cur_ro, cur_rdata}, {1'b1, 32'h0});
    end
    $display("txn inst=0 WR+RD addr=00000008 data=deadbeef");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    cur = 2'd1;
    for (int i = 0; i < 10; i++) begin
      exp_d = (i >= 5 && i <= 8) ? 32'(i - 4) : 32'h0;
      n_cmp++;
      if ({cur_ro, cur_resp, cur_rdata} !== {1'b1, 2'b00, exp_d}) begin
        n_bad++; $display("FAIL b2b cyc=%0d: got %h want %h", i,
                          {cur_ro, cur_resp, cur_rdata}, {1'b1, 2'b00, exp_d});
      end
      if (i >= 1 && i <= 4) hwdata = 32'(i);
      if (i < 4)      addr_phase(2'b10, 1'b1, 32'(4 * i), 3'b010);
      else if (i < 8) addr_phase(2'b10, 1'b0, 32'(4 * (i - 4)), 3'b010);
      else            bus_idle();
      @(negedge clk);
    end
    $display("txn inst=1 B2B 4 writes + 4 reads");
  endtask

  task automatic test_burst_top();
    logic [2:0] exp_v [5];
    exp_v = '{3'b1_00, 3'b1_00, 3'b0_01, 3'b1_01, 3'b1_00};
    cur = 2'd1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       addr_phase(2'b10, 1'b0, 32'h38, 3'b010);
        1:       addr_phase(2'b11, 1'b0, 32'h3C, 3'b010);
        2:       addr_phase(2'b11, 1'b0, 32'h40, 3'b010);
        default: bus_idle();
      endcase
      @(negedge clk);
      n_cmp++;
      if ({cur_ro, cur_resp} !== exp_v[i]) begin
        n_bad++; $display("FAIL burst_top beat=%0d: got %b want %b", i, {cur_ro, cur_resp}, exp_v[i]);
      end
    end
    $display("txn inst=1 burst 38,3C,40");
  endtask

  task automatic test_errors();
    logic [2:0]  exp_v [3];
    logic [1:0]  r;
    logic [31:0] d;
    int          k;
    bit          ok;
    exp_v = '{3'b0_01, 3'b1_01, 3'b1_00};
    cur = 2'd0;
    addr_phase(2'b10, 1'b0, 32'h40, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_idle();
      n_cmp++;
      if ({cur_ro, cur_resp} !== exp_v[i]) begin
        n_bad++; $display("FAIL err_range cyc=%0d: got %b want %b", i, {cur_ro, cur_resp}, exp_v[i]);
      end
    end
    do_write(32'h06, 32'h0BAD_0BAD, 3'b010, r, k, ok);
    n_cmp++;
    if (!ok || r !== 2'b01 || k != 1) begin
      n_bad++; $display("FAIL err_unaligned: got resp=%0d waits=%0d want resp=1 waits=1", r, k);
    end
    do_write(32'h08, 32'h5555_5555, 3'b000, r, k, ok);
    n_cmp++;
    if (!ok || r !== 2'b01 || k != 1) begin
      n_bad++; $display("FAIL err_size: got resp=%0d waits=%0d want resp=1 waits=1", r, k);
    end
    do_read(32'h04, d, r, ok);
    n_cmp++;
    if (!ok || {r, d} !== {2'b00, 32'h0}) begin
      n_bad++; $display("FAIL err_rb_04: got %h want %h", {r, d}, {2'b00, 32'h0});
    end
    do_read(32'h08, d, r, ok);
    n_cmp++;
    if (!ok || {r, d} !== {2'b00, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL err_rb_08: got %h want %h", {r, d}, {2'b00, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_busy_unsel();
    logic [1:0]  r;
    logic [31:0] d;
    int          k;
    bit          ok;
    cur = 2'd0;
    do_write(32'h00, 32'hA5A5_A5A5, 3'b010, r, k, ok);
    n_cmp++;
    if (!ok || r !== 2'b00 || k != 1) begin
      n_bad++; $display("FAIL ws1_okay_write: got resp=%0d waits=%0d want resp=0 waits=1", r, k);
    end
    for (int i = 0; i < 2; i++) begin
      addr_phase(i == 0 ? 2'b01 : 2'b10, 1'b1, 32'h00, 3'b010);
      if (i == 1) hsel = 1'b0;
      @(negedge clk);
      bus_idle();
      hwdata = 32'hFFFF_FFFF;
      n_cmp++;
      if ({cur_ro, cur_resp} !== 3'b1_00) begin
        n_bad++; $display("FAIL busy_unsel case=%0d: got %b want 100", i, {cur_ro, cur_resp});
      end
      @(negedge clk);
    end
    do_read(32'h00, d, r, ok);
    n_cmp++;
    if (!ok || {r, d} !== {2'b00, 32'hA5A5_A5A5}) begin
      n_bad++; $display("FAIL busy_rb_00: got %h want %h", {r, d}, {2'b00, 32'hA5A5_A5A5});
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0]  r;
    logic [31:0] d;
    int          k;
    bit          ok;
    cur = 2'd2;
    addr_phase(2'b10, 1'b1, 32'h10, 3'b010);
    @(negedge clk);
    bus_idle();
    hwdata = 32'h0000_1234;
    n_cmp++;
    if (cur_ro !== 1'b0) begin
      n_bad++; $display("FAIL ws3_wait1: got %b want 0", cur_ro);
    end
    @(negedge clk);
    n_cmp++;
    if (cur_ro !== 1'b0) begin
      n_bad++; $display("FAIL ws3_wait2: got %b want 0", cur_ro);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cur_ro, cur_resp, cur_rdata} !== {1'b1, 2'b00, 32'h0}) begin
      n_bad++; $display("FAIL mid_reset_out: got %h want %h", {cur_ro, cur_resp, cur_rdata},
                        {1'b1, 2'b00, 32'h0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_read(32'h10, d, r, ok);
    n_cmp++;
    if (!ok || {r, d} !== {2'b00, 32'h0}) begin
      n_bad++; $display("FAIL mid_reset_rb_10: got %h want %h", {r, d}, {2'b00, 32'h0});
    end
    do_write(32'h14, 32'h0000_0099, 3'b010, r, k, ok);
    n_cmp++;
    if (!ok || r !== 2'b00 || k != 3) begin
      n_bad++; $display("FAIL ws3_latency: got resp=%0d waits=%0d want resp=0 waits=3", r, k);
    end
    do_read(32'h14, d, r, ok);
    n_cmp++;
    if (!ok || {r, d} !== {2'b00, 32'h0000_0099}) begin
      n_bad++; $display("FAIL ws3_rb_14: got %h want %h", {r, d}, {2'b00, 32'h0000_0099});
    end
    cur = 2'd0;
    do_read(32'h08, d, r, ok);
    n_cmp++;
    if (!ok || {r, d} !== {2'b00, 32'h0}) begin
      n_bad++; $display("FAIL reset_cleared_ws1: got %h want %h", {r, d}, {2'b00, 32'h0});
    end
  endtask

  initial begin
    test_reset();
    test_write_read_ws1();
    test_back_to_back();
    test_burst_top();
    test_errors();
    test_busy_unsel();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_sub_mem.md
Name: ahb_sub_mem

Overview:
AHB subordinate word memory that sits directly downstream of the AHB manager on the shared address/data bus. It consumes HADDR/HTRANS/HWRITE/HSIZE/HWDATA and returns HRDATA/HREADYOUT/HRESP. It supports configurable wait states and a two-cycle ERROR response for illegal accesses. It is the first real target for bring-up of the manager's address and data pipeline.

Parameters:
MEM_DEPTH, 16, number of 32-bit words (power of 2, 2..256)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to MEM_DEPTH*4)
WAIT_STATES, 1, extra HREADYOUT-low cycles per OKAY data phase (0..7)

Ports:
HCLK  in  1  bus clock; all logic on rising edge
HRESETn  in  1  synchronous active-low reset, sampled on HCLK rising edge
HSEL  in  1  decoder select for this subordinate
HADDR  in  32  byte address (address phase)
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write, 0 = read (address phase)
HSIZE  in  3  transfer size; only 3'b010 (word) is legal
HBURST  in  3  accepted but ignored; each beat is decoded independently
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-level ready; an address phase is sampled only when 1
HREADYOUT  out  1  this subordinate's ready for the current data phase
HRESP  out  2  00 OKAY, 01 ERROR (RETRY/SPLIT are never driven)
HRDATA  out  32  read data; valid when HREADYOUT=1 in a read data phase

Behaviour:
- Reset (HRESETn=0 at a clock edge): HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0, all memory words cleared to 0. Reset mid-transfer abandons the transfer. No memory write occurs.
- Address phase accepted when HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance, register the word index HADDR[log2(MEM_DEPTH)+1:2], HWRITE, and an error flag.
- Error flag is set if any of the following holds: HADDR outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH-1]; HSIZE≠010; HADDR[1:0]≠00.
- IDLE/BUSY, or HSEL=0, with HREADY=1: no transfer. The next cycle responds zero-wait OKAY (HREADYOUT=1, HRESP=00).
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: counting wait states.
  - DATA: final OKAY cycle.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01.
- Transitions:
  - Accepted with error flag -> ERR1 -> ERR2.
  - Accepted without error, WAIT_STATES=0 -> DATA.
  - Accepted without error, WAIT_STATES>0 -> WAIT for exactly WAIT_STATES cycles (HREADYOUT=0, HRESP=00) -> DATA.
  - DATA or ERR2 -> IDLE, unless a new address phase is accepted in that same cycle, in which case go directly to that transfer's first state (back-to-back pipelining, no bubble).
- Address phases are never sampled while HREADYOUT=0 (HREADY is low bus-wide).
- Write: in the DATA cycle, HWDATA is written to mem[index] at the rising edge ending that cycle. ERROR transfers never write.
- Read: in the DATA cycle, HRDATA = mem[index]. In all other cycles HRDATA = 0.
- Read-after-write to the same word, back-to-back: the read returns the new data. The write commits at the end of the write's DATA cycle, before the read's data phase.
- Latency from accepted address to data completion: WAIT_STATES+1 cycles. Error transfers take exactly 2 cycles regardless of WAIT_STATES.
- HBURST is ignored. An incrementing burst crossing the top of the range produces ERROR on the out-of-range beat only.

Test Plan:
- Reset then idle: hold HRESETn=0 for 2 cycles, then HTRANS=00 -> HREADYOUT=1, HRESP=00, HRDATA=0 every cycle.
- Write/read, WAIT_STATES=1: NONSEQ write to 0x08 with data 0xDEAD_BEEF, then NONSEQ read of 0x08 -> write phase has HREADYOUT low for 1 cycle; read data phase returns 0xDEAD_BEEF with HRESP=00.
- Back-to-back pipeline, WAIT_STATES=0: writes to 0x0,0x4,0x8,0xC (values 1..4) with no gaps, then reads of the same addresses -> HREADYOUT=1 every cycle; reads return 1,2,3,4 on consecutive cycles.
- Error cases:
  - Read of 0x40 with MEM_DEPTH=16 -> 1 cycle HREADYOUT=0/HRESP=01, then 1 cycle HREADYOUT=1/HRESP=01.
  - Write to 0x06, or write with HSIZE=000 -> same two-cycle error; memory word unchanged on readback.
- Reset mid-wait: WAIT_STATES=3 write of 0x1234 to 0x10, assert HRESETn=0 during the second wait cycle -> outputs return to reset values; readback of 0x10 returns 0.
- BUSY/unselected: HTRANS=01, or HSEL=0 with HTRANS=10 write to 0x0 -> zero-wait OKAY; readback of 0x0 unchanged.
